pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the payload width (data, addresses, instruction) carried through the stage.
REQ-002 The block SHALL have parameter CTRL_W, default 2, meaning the control-bit width, zeroed whenever the stage holds a bubble.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the stall-counter width.
REQ-004 Ports, in order:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  upstream entry valid.
- ready_o  out  1  stage accepts an entry this cycle.
- ctrl_i  in  CTRL_W  upstream control bits.
- data_i  in  DATA_W  upstream payload.
- stall_i  in  1  hazard stall, blocks acceptance.
- flush_i  in  1  discard all held entries.
- valid_o  out  1  output entry valid.
- ready_i  in  1  downstream accepts output.
- ctrl_o  out  CTRL_W  output control bits.
- data_o  out  DATA_W  output payload.
- stall_cnt_o  out  CNT_W  count of blocked cycles.

Function
REQ-005 Input transfer SHALL occur on a rising edge where valid_i=1 and ready_o=1; output transfer SHALL occur where valid_o=1 and ready_i=1.
REQ-006 Without skid, ready_o SHALL equal ~stall_i & (~valid_o | ready_i), combinationally.
REQ-007 On an input transfer, ctrl_o and data_o SHALL take ctrl_i and data_i, and valid_o SHALL be 1 at the next edge: latency 1 cycle.
REQ-008 On an output transfer with no simultaneous input transfer, valid_o and ctrl_o SHALL become 0 (bubble), and data_o SHALL hold.
REQ-009 With valid_o=1 and ready_i=0, valid_o, ctrl_o and data_o SHALL hold unchanged.
REQ-010 stall_i=1 SHALL force ready_o=0 but SHALL NOT block an output transfer, so the stage drains into a bubble.
REQ-011 flush_i=1 SHALL, at the next edge, clear every valid bit and all ctrl state to 0 and hold data state; flush SHALL take priority over simultaneous input and output transfers.
REQ-012 stall_cnt_o SHALL increment by 1 on each edge where valid_i=1 and ready_o=0, and SHALL saturate at 2^CNT_W-1.
REQ-013 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or dropped except by flush_i.

Reset
REQ-014 Asserting rst_i=0 SHALL immediately, without waiting for a clock edge, clear the following to 0: valid_o, ctrl_o, data_o, stall_cnt_o and all skid state.
REQ-015 Reset asserted mid-transfer SHALL discard the in-flight entry.
REQ-016 After rst_i rises, the first input transfer SHALL be possible on the first rising edge.

Configuration
REQ-017 Macro PIPE_STAGE_SKID_EN SHALL, when defined, add one skid entry (skid_valid, skid_ctrl, skid_data) behind the output register.
REQ-018 With PIPE_STAGE_SKID_EN, ready_o SHALL equal ~skid_valid & ~stall_i, with no combinational path from ready_i.
REQ-019 With PIPE_STAGE_SKID_EN:
- an input transfer while valid_o=1 and ready_i=0 SHALL fill the skid entry;
- the next output transfer SHALL move the skid entry to the output and clear skid_valid.
REQ-020 With PIPE_STAGE_SKID_EN, a simultaneous output transfer and input transfer with skid empty SHALL load the output directly.
REQ-021 Without PIPE_STAGE_SKID_EN, no skid storage SHALL exist and REQ-006 SHALL apply.

Verification
REQ-022 Reset then stream: rst_i=0→1; valid_i=1 with data_i=0x11,0x22,0x33 and ready_i=1 → data_o=0x11,0x22,0x33 on consecutive cycles, each one cycle after entry, with valid_o=1.
REQ-023 Backpressure: hold ready_i=0 with data 0xAA held in the stage and valid_i=1, data_i=0xBB:
- no skid: ready_o=0, data_o stays 0xAA;
- skid: 0xBB accepted into skid, ready_o then 0;
- on ready_i=1: 0xAA, then 0xBB.
REQ-024 Flush priority: flush_i=1 with valid_i=1 and ready_i=1 at the same edge → next cycle valid_o=0, ctrl_o=0, and the skid entry is empty.
REQ-025 Stall drain: data 0x5 held, stall_i=1, ready_i=1 → next cycle valid_o=0, ctrl_o=0, ready_o=0; stall_cnt_o increments each cycle valid_i=1.
REQ-026 Counter saturation: CNT_W=4 with 20 blocked cycles → stall_cnt_o=0xF and holds.
REQ-027 Async reset: rst_i=0 mid-cycle with valid_o=1 → valid_o=0 before the next clock edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// One-entry pipeline stage register with stall, flush and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add one skid entry that breaks the ready_i -> ready_o path.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and a held entry stays stable until it transfers.

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_q & ready_i;

  assign valid_o     = valid_q;
  assign ctrl_o      = ctrl_q;
  assign data_o      = data_q;
  assign stall_cnt_o = cnt_q;

  // Counts cycles where upstream offers an entry but the stage refuses it.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_i && !ready_o && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef PIPE_STAGE_SKID_EN

  logic              skid_valid, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data,  skid_data_d;

  assign ready_o = ~skid_valid & ~stall_i;

  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    data_d       = data_q;
    skid_valid_d = skid_valid;
    skid_ctrl_d  = skid_ctrl;
    skid_data_d  = skid_data;
    if (flush_i) begin
      valid_d      = 1'b0;
      ctrl_d       = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (out_xfer) begin
      if (skid_valid) begin
        // ready_o is low while the skid is full, so no input can arrive here.
        valid_d      = 1'b1;
        ctrl_d       = skid_ctrl;
        data_d       = skid_data;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
      end else if (in_xfer) begin
        valid_d = 1'b1;
        ctrl_d  = ctrl_i;
        data_d  = data_i;
      end else begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
    end else if (in_xfer) begin
      if (valid_q) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = ctrl_i;
        skid_data_d  = data_i;
      end else begin
        valid_d = 1'b1;
        ctrl_d  = ctrl_i;
        data_d  = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else begin
      skid_valid <= skid_valid_d;
      skid_ctrl  <= skid_ctrl_d;
      skid_data  <= skid_data_d;
    end
  end

`else

  // Without skid storage the stage can only accept when its slot is free or draining.
  assign ready_o = ~stall_i & (~valid_q | ready_i);

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (in_xfer) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end else if (out_xfer) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: vector table plus backpressure, flush,
// saturation and async-reset sequences; expectations follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

  localparam int DATA_W = 8;
  localparam int CTRL_W = 2;
  localparam int CNT_W  = 4;

  logic              clk_i;
  logic              rst_i;
  logic              valid_i;
  logic              ready_o;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data_i;
  logic              stall_i;
  logic              flush_i;
  logic              valid_o;
  logic              ready_i;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  int checks;
  int errors;
  int exp_cnt;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .ctrl_i      (ctrl_i),
    .data_i      (data_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .ctrl_o      (ctrl_o),
    .data_o      (data_o),
    .stall_cnt_o (stall_cnt_o)
  );

  // clock block
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic              v;
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
    logic              st;
    logic              fl;
    logic              r;
    logic              chk_rdy;
    logic              er;
    logic              ev;
    logic [CTRL_W-1:0] ec;
    logic [DATA_W-1:0] ed;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle: optional ready_o check before the edge, then outputs and counter after it.
  task automatic step(input string name, input vec_t t);
    valid_i = t.v;
    ctrl_i  = t.c;
    data_i  = t.d;
    stall_i = t.st;
    flush_i = t.fl;
    ready_i = t.r;
    #1;
    if (t.chk_rdy) chk({name, ".ready_o"}, 32'(ready_o), 32'(t.er));
    if (t.v && t.chk_rdy && !t.er && exp_cnt < (2**CNT_W - 1)) exp_cnt++;
    @(posedge clk_i);
    #1;
    chk({name, ".valid_o"}, 32'(valid_o), 32'(t.ev));
    chk({name, ".ctrl_o"},  32'(ctrl_o),  32'(t.ec));
    chk({name, ".data_o"},  32'(data_o),  32'(t.ed));
    chk({name, ".stall_cnt"}, 32'(stall_cnt_o), 32'(exp_cnt));
  endtask

  function automatic vec_t mk(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                              input logic st, input logic fl, input logic r, input logic chk_rdy,
                              input logic er, input logic ev, input logic [CTRL_W-1:0] ec,
                              input logic [DATA_W-1:0] ed);
    vec_t t;
    t.v = v; t.c = c; t.d = d; t.st = st; t.fl = fl; t.r = r;
    t.chk_rdy = chk_rdy; t.er = er; t.ev = ev; t.ec = ec; t.ed = ed;
    return t;
  endfunction

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;

    //            v  c  d      st fl r  ck er ev ec ed
    tbl[0]  = mk(1, 1, 8'h11, 0, 0, 1, 1, 1, 1, 1, 8'h11);
    tbl[1]  = mk(1, 2, 8'h22, 0, 0, 1, 1, 1, 1, 2, 8'h22);
    tbl[2]  = mk(1, 3, 8'h33, 0, 0, 1, 1, 1, 1, 3, 8'h33);
    tbl[3]  = mk(0, 0, 8'h00, 0, 0, 1, 1, 1, 0, 0, 8'h33); // drain to bubble, data holds
    tbl[4]  = mk(1, 1, 8'h05, 0, 0, 1, 1, 1, 1, 1, 8'h05);
    tbl[5]  = mk(1, 2, 8'h66, 1, 0, 1, 1, 0, 0, 0, 8'h05); // stall drains, counts
    tbl[6]  = mk(1, 2, 8'h66, 1, 0, 1, 1, 0, 0, 0, 8'h05);
    tbl[7]  = mk(1, 3, 8'h77, 0, 0, 0, 1, 1, 1, 3, 8'h77); // empty slot accepts despite ready_i=0
    tbl[8]  = mk(1, 1, 8'h88, 0, 1, 1, 1, 1, 0, 0, 8'h77); // flush beats in/out transfer
    tbl[9]  = mk(1, 2, 8'h99, 0, 0, 1, 1, 1, 1, 2, 8'h99);
    tbl[10] = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 2, 8'h99); // backpressured hold
    tbl[11] = mk(0, 0, 8'h00, 0, 0, 1, 1, 1, 0, 0, 8'h99);

    // reset block
    rst_i = 1'b0; valid_i = 1'b0; ctrl_i = '0; data_i = '0;
    stall_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    #2;
    chk("reset.valid_o", 32'(valid_o), 32'd0);
    chk("reset.ctrl_o", 32'(ctrl_o), 32'd0);
    chk("reset.data_o", 32'(data_o), 32'd0);
    chk("reset.stall_cnt", 32'(stall_cnt_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    for (int i = 0; i < 12; i++) step($sformatf("vec%0d", i), tbl[i]);

    // backpressure: 0xAA held, 0xBB offered
    step("bp0", mk(1, 1, 8'hAA, 0, 0, 1, 1, 1, 1, 1, 8'hAA));
`ifdef PIPE_STAGE_SKID_EN
    step("bp1", mk(1, 2, 8'hBB, 0, 0, 0, 1, 1, 1, 1, 8'hAA));
    step("bp2", mk(1, 3, 8'hCC, 0, 0, 0, 1, 0, 1, 1, 8'hAA));
    step("bp3", mk(0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 2, 8'hBB));
    step("bp4", mk(0, 0, 8'h00, 0, 0, 1, 1, 1, 0, 0, 8'hBB));
`else
    step("bp1", mk(1, 2, 8'hBB, 0, 0, 0, 1, 0, 1, 1, 8'hAA));
    step("bp2", mk(1, 2, 8'hBB, 0, 0, 0, 1, 0, 1, 1, 8'hAA));
    step("bp3", mk(1, 2, 8'hBB, 0, 0, 1, 1, 1, 1, 2, 8'hBB));
    step("bp4", mk(0, 0, 8'h00, 0, 0, 1, 1, 1, 0, 0, 8'hBB));
`endif

    // flush while an extra entry may sit in the skid
    step("fl0", mk(1, 1, 8'hAA, 0, 0, 1, 1, 1, 1, 1, 8'hAA));
`ifdef PIPE_STAGE_SKID_EN
    step("fl1", mk(1, 2, 8'hBB, 0, 0, 0, 1, 1, 1, 1, 8'hAA));
    step("fl2", mk(1, 3, 8'hCC, 0, 1, 1, 1, 0, 0, 0, 8'hAA));
`else
    step("fl1", mk(1, 2, 8'hBB, 0, 0, 0, 1, 0, 1, 1, 8'hAA));
    step("fl2", mk(1, 3, 8'hCC, 0, 1, 1, 1, 1, 0, 0, 8'hAA));
`endif
    step("fl3", mk(0, 0, 8'h00, 0, 0, 1, 1, 1, 0, 0, 8'hAA));

    // counter saturation
    for (int i = 0; i < 20; i++) step($sformatf("sat%0d", i), mk(1, 1, 8'h42, 1, 0, 1, 1, 0, 0, 0, 8'hAA));
    chk("sat.final", 32'(stall_cnt_o), 32'hF);

    // async reset mid-cycle with a valid entry held
    step("ar0", mk(1, 1, 8'h5A, 0, 0, 0, 1, 1, 1, 1, 8'h5A));
    valid_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    chk("ar.valid_o", 32'(valid_o), 32'd0);
    chk("ar.ctrl_o", 32'(ctrl_o), 32'd0);
    chk("ar.data_o", 32'(data_o), 32'd0);
    chk("ar.stall_cnt", 32'(stall_cnt_o), 32'd0);
    exp_cnt = 0;
    #1;
    rst_i = 1'b1;
    step("ar1", mk(1, 2, 8'h3C, 0, 0, 1, 1, 1, 1, 2, 8'h3C));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
